// File: rtl/fp32_pkg.sv
//==============================================================================
// fp32_pkg - shared binary32 constants, flag indices, FSM state and operand class
// Revision: 1.0
//==============================================================================
`default_nettype none

package fp32_pkg;

   localparam int          EXP_W = 8;
   localparam int          MAN_W = 23;
   localparam int          BIAS  = 127;
   localparam logic [31:0] QNAN  = 32'h7FC00000;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_DIV_ZERO  = 2;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UNPACK = 3'd1,
      ST_DIV    = 3'd2,
      ST_ROUND  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CLS_ZERO   = 2'd0,
      CLS_NORMAL = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } fp_class_t;

endpackage

`default_nettype wire

// File: rtl/fp32_classify.sv
//==============================================================================
// fp32_classify - combinational binary32 operand decode (class, sign, exp, sig)
// Revision: 1.0
//==============================================================================
`default_nettype none

module fp32_classify
   import fp32_pkg::*;
#(
   parameter int FLUSH_DENORM = 1
) (
   input  logic [31:0]      value,
   output fp_class_t        cls,
   output logic             sign,
   output logic [EXP_W-1:0] exponent,
   output logic [MAN_W:0]   significand
);

   logic [EXP_W-1:0] w_exp;
   logic [MAN_W-1:0] w_frac;
   logic             w_exp_zero;
   logic             w_exp_ones;

   assign w_exp      = value[30:23];
   assign w_frac     = value[22:0];
   assign w_exp_zero = (w_exp == '0);
   assign w_exp_ones = (w_exp == '1);
   assign sign       = value[31];
   assign exponent   = w_exp;

   always_comb begin
      cls         = CLS_NORMAL;
      significand = {1'b1, w_frac};
      if (w_exp_ones) begin
         cls = (w_frac != '0) ? CLS_NAN : CLS_INF;
      end else if (w_exp_zero && (FLUSH_DENORM != 0 || w_frac == '0)) begin
         // Subnormals are read as signed zero.
         cls         = CLS_ZERO;
         significand = '0;
      end else if (w_exp_zero) begin
         significand = {1'b0, w_frac};
      end
   end

endmodule

`default_nettype wire

// File: rtl/fp32_div_seq.sv
//==============================================================================
// fp32_div_seq - sequential binary32 divider, radix-2 restoring, 1 bit/cycle
// Revision: 1.0
//==============================================================================
`default_nettype none

module fp32_div_seq
   import fp32_pkg::*;
#(
   parameter int FLUSH_DENORM = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic [3:0]  flags
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [24:0]        r_rem;
   logic [24:0]        r_q;
   logic signed [9:0]  r_exp;
   logic [4:0]         r_cnt;
   logic [31:0]        r_out;
   logic [3:0]         r_flags;

   fp_class_t          w_cls_a;
   fp_class_t          w_cls_b;
   logic               w_sign_a;
   logic               w_sign_b;
   logic [EXP_W-1:0]   w_exp_a;
   logic [EXP_W-1:0]   w_exp_b;
   logic [MAN_W:0]     w_sig_a;
   logic [MAN_W:0]     w_sig_b;
   logic               w_sign;

   logic               w_special;
   logic [31:0]        w_spec_out;
   logic [3:0]         w_spec_flags;

   logic               w_ma_lt;
   logic signed [9:0]  w_exp_init;
   logic [24:0]        w_rem_init;

   logic               w_rem_ge;
   logic [24:0]        w_rem_kept;

   logic               w_sticky;
   logic               w_inc;
   logic [23:0]        w_man_sum;
   logic signed [9:0]  w_exp_rnd;
   logic [31:0]        w_rnd_out;
   logic [3:0]         w_rnd_flags;

   fp32_classify #(.FLUSH_DENORM(FLUSH_DENORM)) u_cls_a (
      .value       (r_a),
      .cls         (w_cls_a),
      .sign        (w_sign_a),
      .exponent    (w_exp_a),
      .significand (w_sig_a)
   );

   fp32_classify #(.FLUSH_DENORM(FLUSH_DENORM)) u_cls_b (
      .value       (r_b),
      .cls         (w_cls_b),
      .sign        (w_sign_b),
      .exponent    (w_exp_b),
      .significand (w_sig_b)
   );

   assign w_sign = w_sign_a ^ w_sign_b;

   // Special-operand resolution; the order of the branches is the priority.
   always_comb begin
      w_special    = 1'b1;
      w_spec_out   = QNAN;
      w_spec_flags = 4'h0;
      if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN) begin
         w_spec_out = QNAN;
      end else if ((w_cls_a == CLS_ZERO && w_cls_b == CLS_ZERO) ||
                   (w_cls_a == CLS_INF  && w_cls_b == CLS_INF)) begin
         w_spec_flags[FLAG_INVALID] = 1'b1;
      end else if (w_cls_a == CLS_NORMAL && w_cls_b == CLS_ZERO) begin
         w_spec_out                  = {w_sign, 8'hFF, 23'h0};
         w_spec_flags[FLAG_DIV_ZERO] = 1'b1;
      end else if (w_cls_a == CLS_INF) begin
         w_spec_out = {w_sign, 8'hFF, 23'h0};
      end else if (w_cls_b == CLS_INF || w_cls_a == CLS_ZERO) begin
         w_spec_out = {w_sign, 31'h0};
      end else begin
         w_special = 1'b0;
      end
   end

   // Pre-normalising the dividend keeps the quotient in [1,2).
   assign w_ma_lt    = (w_sig_a < w_sig_b);
   assign w_rem_init = w_ma_lt ? {w_sig_a, 1'b0} : {1'b0, w_sig_a};
   assign w_exp_init = $signed({2'b00, w_exp_a}) - $signed({2'b00, w_exp_b})
                       + 10'sd127 - $signed({9'b0, w_ma_lt});

   assign w_rem_ge   = (r_rem >= {1'b0, w_sig_b});
   assign w_rem_kept = w_rem_ge ? (r_rem - {1'b0, w_sig_b}) : r_rem;

   assign w_sticky  = (r_rem != '0);
   assign w_inc     = r_q[1] & (r_q[0] | w_sticky | r_q[2]);
   assign w_man_sum = {1'b0, r_q[24:2]} + {23'h0, w_inc};
   assign w_exp_rnd = r_exp + $signed({9'b0, w_man_sum[23]});

   always_comb begin
      w_rnd_flags = 4'h0;
      w_rnd_out   = {w_sign, w_exp_rnd[7:0], w_man_sum[22:0]};
      if (w_exp_rnd >= 10'sd255) begin
         w_rnd_out                   = {w_sign, 8'hFF, 23'h0};
         w_rnd_flags[FLAG_OVERFLOW]  = 1'b1;
      end else if (w_exp_rnd <= 10'sd0) begin
         w_rnd_out                   = {w_sign, 31'h0};
         w_rnd_flags[FLAG_UNDERFLOW] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = ST_UNPACK;
         end
         ST_UNPACK: w_state_nxt = w_special ? ST_DONE : ST_DIV;
         ST_DIV:    if (r_cnt == 5'd0) w_state_nxt = ST_ROUND;
         ST_ROUND:  w_state_nxt = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_exp   <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
         r_flags <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a <= in1;
                  r_b <= in2;
               end
            end
            ST_UNPACK: begin
               if (w_special) begin
                  r_out   <= w_spec_out;
                  r_flags <= w_spec_flags;
               end else begin
                  r_rem <= w_rem_init;
                  r_exp <= w_exp_init;
                  r_q   <= '0;
                  r_cnt <= 5'd25;
               end
            end
            ST_DIV: begin
               // The leading quotient bit (always 1) shifts out the top.
               r_q   <= {r_q[23:0], w_rem_ge};
               r_rem <= w_rem_kept << 1;
               r_cnt <= r_cnt - 5'd1;
            end
            ST_ROUND: begin
               r_out   <= w_rnd_out;
               r_flags <= w_rnd_flags;
            end
            default: ;
         endcase
      end
   end

   assign out   = r_out;
   assign flags = r_flags;

endmodule

`default_nettype wire
